// File: rtl/knn_vote.sv
// Majority vote over the K sorted neighbour labels: count phase, scan phase, done pulse.
// Optional distance weighting (nearest slot counts K) is enabled by defining KNN_VOTE_WEIGHT_EN.
module knn_vote #(
    parameter int K         = 10,
    parameter int LABEL_W   = 8,
    parameter int N_CLASSES = 10,
    parameter int CNT_W     = $clog2(K + 1),
    parameter int VOTE_W    = $clog2(K * (K + 1) / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [K*LABEL_W-1:0] neighbours,
    input  logic [CNT_W-1:0]     valid_cnt,
    output logic                 busy,
    output logic                 done,
    output logic [LABEL_W-1:0]   label,
    output logic [VOTE_W-1:0]    votes
);

    // state | meaning
    // IDLE  | waiting for start, result outputs hold
    // COUNT | one neighbour slot per cycle added to its class tally
    // SCAN  | one class per cycle compared against the running best
    // DONE  | publish best class and its tally with a one-cycle done
    localparam int IDX_MAX = (K > N_CLASSES) ? K : N_CLASSES;
    localparam int IDX_W   = $clog2(IDX_MAX + 1);

    typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

    state_t               state;
    logic [K*LABEL_W-1:0] nb_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx;
    logic [VOTE_W-1:0]    tally [N_CLASSES];
    logic [LABEL_W-1:0]   best_label;
    logic [VOTE_W-1:0]    best_votes;
    logic [LABEL_W-1:0]   cur_label;
    logic                 slot_hit;
    logic [VOTE_W-1:0]    inc;
    logic [VOTE_W-1:0]    scan_tally;

    // The latched list shifts down one slot per COUNT cycle, so slot idx is always at the bottom.
    assign cur_label = nb_q[LABEL_W-1:0];

    always_comb begin
        slot_hit = (int'(idx) < int'(cnt_q)) && (int'(cur_label) < N_CLASSES);
`ifdef KNN_VOTE_WEIGHT_EN
        inc = VOTE_W'(K - int'(idx));
`else
        inc = VOTE_W'(1);
`endif
    end

    always_comb begin
        scan_tally = '0;
        for (int c = 0; c < N_CLASSES; c++) begin
            if (int'(idx) == c) scan_tally = tally[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            label      <= '0;
            votes      <= '0;
            idx        <= '0;
            nb_q       <= '0;
            cnt_q      <= '0;
            best_label <= '0;
            best_votes <= '0;
            for (int c = 0; c < N_CLASSES; c++) tally[c] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        nb_q  <= neighbours;
                        cnt_q <= (int'(valid_cnt) > K) ? CNT_W'(K) : valid_cnt;
                        for (int c = 0; c < N_CLASSES; c++) tally[c] <= '0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    for (int c = 0; c < N_CLASSES; c++) begin
                        if (slot_hit && int'(cur_label) == c) tally[c] <= tally[c] + inc;
                    end
                    nb_q <= nb_q >> LABEL_W;
                    if (int'(idx) == K - 1) begin
                        idx        <= '0;
                        best_label <= '0;
                        best_votes <= '0;
                        state      <= SCAN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                SCAN: begin
                    // Strictly greater keeps the lowest class index on ties.
                    if (scan_tally > best_votes) begin
                        best_label <= LABEL_W'(idx);
                        best_votes <= scan_tally;
                    end
                    if (int'(idx) == N_CLASSES - 1) state <= DONE;
                    else                            idx   <= idx + IDX_W'(1);
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    label <= best_label;
                    votes <= best_votes;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote at K=4, N_CLASSES=4; expectations follow KNN_VOTE_WEIGHT_EN.
module tb_knn_vote;
    localparam int K  = 4;
    localparam int NC = 4;
    localparam int LW = 8;
    localparam int CW = $clog2(K + 1);
    localparam int VW = $clog2(K * (K + 1) / 2 + 1);
    localparam int LAT = K + NC + 1;

    typedef struct {
        logic [LW-1:0] lab;
        logic [VW-1:0] vot;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [K*LW-1:0] neighbours = '0;
    logic [CW-1:0]   valid_cnt = '0;
    logic            busy, done;
    logic [LW-1:0]   label;
    logic [VW-1:0]   votes;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    knn_vote #(.K(K), .LABEL_W(LW), .N_CLASSES(NC)) dut (
        .clk(clk), .rst(rst), .start(start), .neighbours(neighbours),
        .valid_cnt(valid_cnt), .busy(busy), .done(done), .label(label), .votes(votes)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [K*LW-1:0] nb, input int cnt);
        int   t[NC];
        int   eff;
        int   lab;
        exp_t e;
        for (int c = 0; c < NC; c++) t[c] = 0;
        eff = (cnt > K) ? K : cnt;
        for (int i = 0; i < eff; i++) begin
            lab = int'(nb[i*LW +: LW]);
            if (lab < NC) begin
`ifdef KNN_VOTE_WEIGHT_EN
                t[lab] += K - i;
`else
                t[lab] += 1;
`endif
            end
        end
        e.lab = '0;
        e.vot = '0;
        for (int c = 0; c < NC; c++) begin
            if (t[c] > int'(e.vot)) begin
                e.lab = LW'(c);
                e.vot = VW'(t[c]);
            end
        end
        return e;
    endfunction

    function automatic logic [K*LW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {LW'(d), LW'(c), LW'(b), LW'(a)};
    endfunction

    // Issue one request and follow it to done. poke_at >= 0 pulses start while busy.
    task automatic run_req(input string nm, input logic [K*LW-1:0] nb, input int cnt,
                           input int poke_at);
        exp_t e;
        exp_t got;
        int   n;
        @(negedge clk);
        neighbours = nb;
        valid_cnt  = CW'(cnt);
        start      = 1'b1;
        sb.push_back(model(nb, cnt));
        @(negedge clk);
        start      = 1'b0;
        neighbours = $urandom;
        valid_cnt  = CW'($urandom_range(0, 7));
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy n=%0d got=%b want=1", nm, n, busy);
            end
            start = (poke_at >= 0 && n == poke_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        total++;
        if (n != LAT) begin
            bad++;
            $display("FAIL %s latency got=%0d want=%0d", nm, n, LAT);
        end
        if (done === 1'b1) begin
            e = sb.pop_front();
            got.lab = label;
            got.vot = votes;
            total++;
            if (got.lab !== e.lab || got.vot !== e.vot) begin
                bad++;
                $display("FAIL %s result got label=%0d votes=%0d want label=%0d votes=%0d",
                         nm, got.lab, got.vot, e.lab, e.vot);
            end
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL %s busy_at_done got=%b want=0", nm, busy);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || label !== e.lab || votes !== e.vot) begin
                bad++;
                $display("FAIL %s pulse_hold done=%b label=%0d votes=%0d want 0/%0d/%0d",
                         nm, done, label, votes, e.lab, e.vot);
            end
        end else begin
            void'(sb.pop_front());
        end
    endtask

    task automatic expect_no_done(input string nm, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s extra_done got=%0d want=0", nm, seen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (busy !== 1'b0 || done !== 1'b0 || label !== '0 || votes !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d busy=%b done=%b label=%0d votes=%0d want all 0",
                         i, busy, done, label, votes);
            end
        end
    endtask

    task automatic test_majority();
        run_req("majority", pack4(2, 1, 2, 3), 4, -1);
    endtask

    task automatic test_tie_and_range();
        run_req("tie", pack4(2, 1, 2, 3), 2, -1);
        run_req("out_of_range", pack4(3, 5, 3, 7), 4, -1);
        run_req("weighted_case", pack4(1, 2, 2, 0), 4, -1);
    endtask

    task automatic test_empty();
        run_req("empty", pack4(3, 3, 1, 2), 0, -1);
        total++;
        if (label !== '0 || votes !== '0) begin
            bad++;
            $display("FAIL empty_const got label=%0d votes=%0d want 0/0", label, votes);
        end
    endtask

    task automatic test_back_to_back();
        run_req("busy_start", pack4(0, 1, 1, 3), 4, 3);
        expect_no_done("busy_start", 25);
        run_req("clamp", pack4(3, 2, 3, 2), 7, -1);
        for (int r = 0; r < 4; r++) begin
            run_req("random", pack4($urandom_range(0, 5), $urandom_range(0, 5),
                                    $urandom_range(0, 5), $urandom_range(0, 5)),
                    $urandom_range(0, 7), -1);
        end
    endtask

    task automatic test_abort();
        int n;
        run_req("pre_abort", pack4(1, 1, 0, 2), 4, -1);
        @(negedge clk);
        neighbours = pack4(2, 2, 2, 2);
        valid_cnt  = CW'(4);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < K + 2) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || label !== '0 || votes !== '0) begin
            bad++;
            $display("FAIL abort_reset busy=%b done=%b label=%0d votes=%0d want all 0",
                     busy, done, label, votes);
        end
        expect_no_done("abort", 25);
        run_req("after_abort", pack4(3, 0, 3, 1), 3, -1);
    endtask

    initial begin
        test_reset();
        test_majority();
        test_tie_and_range();
        test_empty();
        test_back_to_back();
        test_abort();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
